// File: rtl/approx_error_monitor.sv
// approx_error_monitor
// Streaming error-metrics stage for an N-bit approximate adder. Each accepted
// sample (op_a, op_b, approx_sum) is compared against the exact sum; the
// absolute error distance (ED) is accumulated over a window of WINDOW samples
// into sample count, erroneous-sample count, total ED and maximum ED.
//
// Pipeline: accept edge captures the sample, stage 1 registers ED/err,
// stage 2 updates the accumulators. A sample accepted at edge k is visible in
// the result outputs after edge k+2.
//
// Optional feature macro: ERR_MAX_EN
//   defined   -> ed_max register and compare logic are built
//   undefined -> ed_max is tied to 0
module approx_error_monitor #(
  parameter int N      = 8,
  parameter int WINDOW = 256,
  parameter int CNT_W  = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N-1:0]         op_a,
  input  logic [N-1:0]         op_b,
  input  logic [N:0]           approx_sum,
  output logic                 busy,
  output logic                 done,
  output logic [CNT_W-1:0]     sample_cnt,
  output logic [CNT_W-1:0]     err_cnt,
  output logic [N+CNT_W:0]     ed_sum,
  output logic [N:0]           ed_max
);

  localparam int EDW  = N + 1;
  localparam int SUMW = N + 1 + CNT_W;

  // Index of the last sample in the window; the accept counter is compared
  // against it so the WINDOWth accept closes the window on the same edge.
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WINDOW - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] acc_cnt;     // samples accepted so far in this window

  // Pipeline valids and data
  logic             s0_v;        // capture register holds a live sample
  logic             s1_v;        // stage-1 ED register holds a live sample
  logic [N-1:0]     a_q;
  logic [N-1:0]     b_q;
  logic [EDW-1:0]   s_q;
  logic [EDW-1:0]   exact;
  logic [EDW-1:0]   ed_c;
  logic [EDW-1:0]   ed_q;
  logic             err_q;

  // A start cycle never accepts: start takes priority over any offered sample.
  logic accept;
  assign accept = in_valid && in_ready && (state == RUN) && !start;

  // Control FSM with registered handshake and status outputs.
  // NOTE: sequential state is always written with non-blocking (<=) so every
  // register samples the pre-edge values of the others, regardless of order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      in_ready <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      acc_cnt  <= '0;
    end else if (start) begin
      // Start from any state opens a fresh window.
      state    <= RUN;
      in_ready <= 1'b1;
      busy     <= 1'b1;
      done     <= 1'b0;
      acc_cnt  <= '0;
    end else begin
      case (state)
        RUN: begin
          if (accept) begin
            acc_cnt <= acc_cnt + CNT_W'(1);
            if (acc_cnt == LAST_IDX) begin
              state    <= DRAIN;
              in_ready <= 1'b0;
            end
          end
        end
        DRAIN: begin
          // Once the capture register is empty, the last live sample sits in
          // stage 1 and is folded into the accumulators on this same edge.
          if (!s0_v) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Pipeline valid bits; start flushes anything in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0_v <= 1'b0;
      s1_v <= 1'b0;
    end else if (start) begin
      s0_v <= 1'b0;
      s1_v <= 1'b0;
    end else begin
      s0_v <= accept;
      s1_v <= s0_v;
    end
  end

  // Capture the accepted sample.
  // NOTE: pure datapath registers carry no reset; their contents are only
  // consumed when the matching valid bit (which is reset) is set.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_q <= op_a;
      b_q <= op_b;
      s_q <= approx_sum;
    end
  end

  // Exact sum and absolute error distance of the captured sample.
  // NOTE: every always_comb output gets a value on every path so no latch is
  // inferred.
  always_comb begin
    exact = {1'b0, a_q} + {1'b0, b_q};
    if (exact >= s_q) begin
      ed_c = exact - s_q;
    end else begin
      ed_c = s_q - exact;
    end
  end

  // Stage 1: register ED and the error flag.
  always_ff @(posedge clk) begin
    if (s0_v) begin
      ed_q  <= ed_c;
      err_q <= (ed_c != '0);
    end
  end

  // Stage 2: window accumulators; frozen whenever no sample is in stage 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample_cnt <= '0;
      err_cnt    <= '0;
      ed_sum     <= '0;
    end else if (start) begin
      sample_cnt <= '0;
      err_cnt    <= '0;
      ed_sum     <= '0;
    end else if (s1_v) begin
      sample_cnt <= sample_cnt + CNT_W'(1);
      err_cnt    <= err_cnt + CNT_W'(err_q);
      ed_sum     <= ed_sum + SUMW'(ed_q);
    end
  end

`ifdef ERR_MAX_EN
  // Stage 2: running maximum ED over the window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ed_max <= '0;
    end else if (start) begin
      ed_max <= '0;
    end else if (s1_v && (ed_q > ed_max)) begin
      ed_max <= ed_q;
    end
  end
`else
  assign ed_max = '0;
`endif

endmodule

// File: tb/tb_approx_error_monitor.sv
// tb_approx_error_monitor
// Self-checking bench for approx_error_monitor (WINDOW = 4). A behavioural
// model folds every accepted sample into expected window metrics using plain
// integer arithmetic; directed vectors and $urandom windows are compared
// against it, plus latency, handshake, restart and reset-abort behaviour.
module tb_approx_error_monitor;

  localparam int N      = 8;
  localparam int WINDOW = 4;
  localparam int CNT_W  = 16;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 start;
  logic                 in_valid;
  logic                 in_ready;
  logic [N-1:0]         op_a;
  logic [N-1:0]         op_b;
  logic [N:0]           approx_sum;
  logic                 busy;
  logic                 done;
  logic [CNT_W-1:0]     sample_cnt;
  logic [CNT_W-1:0]     err_cnt;
  logic [N+CNT_W:0]     ed_sum;
  logic [N:0]           ed_max;

  approx_error_monitor #(.N(N), .WINDOW(WINDOW), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .op_a       (op_a),
    .op_b       (op_b),
    .approx_sum (approx_sum),
    .busy       (busy),
    .done       (done),
    .sample_cnt (sample_cnt),
    .err_cnt    (err_cnt),
    .ed_sum     (ed_sum),
    .ed_max     (ed_max)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  int m_cnt, m_err, m_sum, m_max;

  // Samples waiting to be offered
  logic [N-1:0] qa[$];
  logic [N-1:0] qb[$];
  logic [N:0]   qs[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    m_cnt = 0; m_err = 0; m_sum = 0; m_max = 0;
  endtask

  task automatic model_add(input logic [N-1:0] a, input logic [N-1:0] b, input logic [N:0] s);
    int ed;
    ed = int'(a) + int'(b) - int'(s);
    if (ed < 0) ed = -ed;
    m_cnt++;
    if (ed != 0) m_err++;
    m_sum += ed;
    if (ed > m_max) m_max = ed;
  endtask

  task automatic push(input logic [N-1:0] a, input logic [N-1:0] b, input logic [N:0] s);
    qa.push_back(a); qb.push_back(b); qs.push_back(s);
  endtask

  task automatic push_random();
    logic [N-1:0] a, b;
    logic [N:0]   ex, s;
    a  = N'($urandom);
    b  = N'($urandom);
    ex = {1'b0, a} + {1'b0, b};
    case ($urandom_range(2))
      0:       s = ex;
      1:       s = ex ^ (N+1)'($urandom_range(15));
      default: s = (N+1)'($urandom);
    endcase
    push(a, b, s);
  endtask

  task automatic check_results(input string tag);
    check({tag, "_sample_cnt"}, 64'(sample_cnt), 64'(m_cnt));
    check({tag, "_err_cnt"},    64'(err_cnt),    64'(m_err));
    check({tag, "_ed_sum"},     64'(ed_sum),     64'(m_sum));
`ifdef ERR_MAX_EN
    check({tag, "_ed_max"},     64'(ed_max),     64'(m_max));
`else
    check({tag, "_ed_max"},     64'(ed_max),     64'd0);
`endif
  endtask

  // Pulse start with a (to be ignored) valid sample on the same cycle.
  task automatic do_start();
    @(negedge clk);
    start      = 1'b1;
    in_valid   = 1'b1;
    op_a       = N'($urandom);
    op_b       = N'($urandom);
    approx_sum = (N+1)'($urandom);
    @(negedge clk);
    start    = 1'b0;
    in_valid = 1'b0;
    model_clear();
    check("start_in_ready", 64'(in_ready), 64'd1);
    check("start_busy", 64'(busy), 64'd1);
    check("start_done", 64'(done), 64'd0);
    check("start_sample_cnt", 64'(sample_cnt), 64'd0);
  endtask

  // Offer queued samples; toggle=1 alternates in_valid every cycle, otherwise
  // in_valid is high with probability pct. Returns just before the edge that
  // accepts the last sample.
  task automatic feed(input bit toggle, input int pct);
    int budget;
    budget = 400;
    while (qa.size() > 0 && budget > 0) begin
      @(negedge clk);
      budget--;
      if (toggle) in_valid = ~in_valid;
      else        in_valid = ($urandom_range(99) < pct);
      if (in_valid) begin
        op_a = qa[0]; op_b = qb[0]; approx_sum = qs[0];
      end else begin
        op_a = N'($urandom); op_b = N'($urandom); approx_sum = (N+1)'($urandom);
      end
      if (in_valid && in_ready) begin
        model_add(qa[0], qb[0], qs[0]);
        void'(qa.pop_front()); void'(qb.pop_front()); void'(qs.pop_front());
      end
    end
    if (qa.size() > 0) begin
      check("feed_timeout_left", 64'(qa.size()), 64'd0);
      qa.delete(); qb.delete(); qs.delete();
    end
  endtask

  // Follow the window from the last-accept edge k through done at k+2.
  // hold5 keeps an extra sample offered the whole time.
  task automatic finish_window(input string tag, input bit hold5);
    @(negedge clk);                       // after edge k
    in_valid = hold5;
    op_a = N'($urandom); op_b = N'($urandom); approx_sum = (N+1)'($urandom);
    check({tag, "_ready_drop"}, 64'(in_ready), 64'd0);
    check({tag, "_busy_drain"}, 64'(busy), 64'd1);
    check({tag, "_done_k"}, 64'(done), 64'd0);
    @(negedge clk);                       // after edge k+1
    check({tag, "_done_k1"}, 64'(done), 64'd0);
    @(negedge clk);                       // after edge k+2
    check({tag, "_done_k2"}, 64'(done), 64'd1);
    check({tag, "_busy_done"}, 64'(busy), 64'd0);
    check_results(tag);
    if (hold5) begin
      repeat (3) @(negedge clk);
      check({tag, "_ready_5th"}, 64'(in_ready), 64'd0);
      check({tag, "_cnt_after_5th"}, 64'(sample_cnt), 64'(WINDOW));
      check({tag, "_frozen_done"}, 64'(done), 64'd1);
    end
    in_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b1;
    op_a = '0; op_b = '0; approx_sum = '0;
    model_clear();

    // Reset / idle with in_valid asserted
    repeat (3) @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check_results("rst");
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_in_ready", 64'(in_ready), 64'd0);
    check("idle_busy", 64'(busy), 64'd0);
    check_results("idle");
    in_valid = 1'b0;

    // Exact window
    do_start();
    push(8'h30, 8'h05, 9'h035); push(8'h47, 8'h70, 9'h0B7);
    push(8'h40, 8'h77, 9'h0B7); push(8'h14, 8'h42, 9'h056);
    feed(1'b0, 100);
    finish_window("exact", 1'b0);
    check("exact_err_const", 64'(err_cnt), 64'd0);

    // Approximate window
    do_start();
    push(8'h30, 8'h05, 9'h035); push(8'h47, 8'h70, 9'h0B0);
    push(8'h40, 8'h77, 9'h0BF); push(8'h14, 8'h42, 9'h050);
    feed(1'b0, 100);
    finish_window("approx", 1'b0);
    check("approx_ed_sum_const", 64'(ed_sum), 64'd21);
    check("approx_err_const", 64'(err_cnt), 64'd3);

    // Carry and sign handling
    do_start();
    push(8'hFF, 8'hFF, 9'h000); push(8'h01, 8'h00, 9'h003);
    push(8'h00, 8'h00, 9'h000); push(8'h80, 8'h80, 9'h100);
    feed(1'b0, 100);
    finish_window("carry", 1'b0);
    check("carry_ed_sum_const", 64'(ed_sum), 64'h200);

    // Backpressure/bubbles and an extra sample after the window is full
    do_start();
    repeat (WINDOW) push_random();
    feed(1'b1, 0);
    finish_window("bubble", 1'b1);

    // Accept-to-visible latency, then restart with two samples in flight
    do_start();
    @(negedge clk);
    in_valid = 1'b1; op_a = 8'h10; op_b = 8'h20; approx_sum = 9'h033;
    model_add(8'h10, 8'h20, 9'h033);
    @(negedge clk);                       // after accept edge k
    in_valid = 1'b0;
    check("lat_k_cnt", 64'(sample_cnt), 64'd0);
    @(negedge clk);                       // after k+1
    check("lat_k1_cnt", 64'(sample_cnt), 64'd0);
    @(negedge clk);                       // after k+2
    check("lat_k2_cnt", 64'(sample_cnt), 64'd1);
    check("lat_k2_ed_sum", 64'(ed_sum), 64'(m_sum));
    push(8'hAA, 8'h11, 9'h000); push(8'h55, 8'h55, 9'h1FF);
    feed(1'b0, 100);
    do_start();                           // discards the two in-flight samples
    repeat (3) @(negedge clk);
    check("restart_cnt_clear", 64'(sample_cnt), 64'd0);
    check("restart_ed_sum_clear", 64'(ed_sum), 64'd0);
    repeat (WINDOW) push_random();
    feed(1'b0, 100);
    finish_window("restart", 1'b0);

    // Randomized windows
    for (int w = 0; w < 6; w++) begin
      do_start();
      repeat (WINDOW) push_random();
      feed(1'b0, 70);
      finish_window("rand", 1'b0);
    end

    // Reset asserted during DRAIN
    do_start();
    repeat (WINDOW) push_random();
    feed(1'b0, 100);
    @(negedge clk);                       // state now DRAIN
    check("pre_abort_busy", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    model_clear();
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    check("abort_in_ready", 64'(in_ready), 64'd0);
    check_results("abort");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("post_abort_done", 64'(done), 64'd0);
    check_results("post_abort");

    // Normal window after the abort
    do_start();
    repeat (WINDOW) push_random();
    feed(1'b0, 100);
    finish_window("after_abort", 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
